// File: rtl/deadtime_gate_driver.sv
// Dead-time-safe gate stage for a full bridge: two independent legs, each with its own dead-time FSM.
// Optional shoot-through fault latching is built when DEADTIME_SHOOTTHROUGH_FAULT_EN is defined.

module deadtime_gate_leg #(
    parameter int DEADTIME = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       want_high,
    input  logic       want_low,
    input  logic       trip,
    output logic [2:0] state,
    output logic       gate_high,
    output logic       gate_low
);
    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_HIGH  = 3'd1,
        S_LOW   = 3'd2,
        S_DEAD  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t     cur, nxt;
    logic [7:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= S_OFF;
            cnt       <= 8'd0;
            gate_high <= 1'b0;
            gate_low  <= 1'b0;
        end else begin
            cur       <= nxt;
            cnt       <= cnt_nxt;
            gate_high <= (nxt == S_HIGH);
            gate_low  <= (nxt == S_LOW);
        end
    end

    always_comb begin
        nxt     = cur;
        cnt_nxt = cnt;
        if (trip) begin
            nxt = S_FAULT;
        end else begin
            case (cur)
                S_OFF: begin
                    if (want_high)     nxt = S_HIGH;
                    else if (want_low) nxt = S_LOW;
                end
                S_HIGH: begin
                    if (!want_high) begin
                        nxt     = S_DEAD;
                        cnt_nxt = 8'(DEADTIME - 1);
                    end
                end
                S_LOW: begin
                    if (!want_low) begin
                        nxt     = S_DEAD;
                        cnt_nxt = 8'(DEADTIME - 1);
                    end
                end
                S_DEAD: begin
                    // The request is ignored until the full interval has elapsed, even for the same side.
                    if (cnt != 8'd0)    cnt_nxt = cnt - 8'd1;
                    else if (want_high) nxt = S_HIGH;
                    else if (want_low)  nxt = S_LOW;
                    else                nxt = S_OFF;
                end
                S_FAULT: nxt = S_FAULT;
                default: nxt = S_OFF;
            endcase
        end
    end

    assign state = cur;
endmodule

module deadtime_gate_driver #(
    parameter int DEADTIME = 50
) (
    input  logic       i_clock,
    input  logic       i_RESET,
    input  logic       i_enable,
    input  logic [3:0] i_MOSFET,
    output logic [3:0] o_gate,
    output logic       o_fault,
    output logic [7:0] o_debug
);
    logic [3:0]      r_cmd;
    logic            r_en;
    logic [1:0]      want_high, want_low, gate_high, gate_low, dead;
    logic [1:0][2:0] leg_state;
    logic            trip;

    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            r_cmd <= 4'b0000;
            r_en  <= 1'b0;
        end else begin
            r_cmd <= i_MOSFET;
            r_en  <= i_enable;
        end
    end

`ifdef DEADTIME_SHOOTTHROUGH_FAULT_EN
    // Either leg commanding both switches trips both legs, independent of enable.
    assign trip    = |(r_cmd[1:0] & r_cmd[3:2]);
    assign o_fault = (leg_state[0] == 3'd4);
`else
    assign trip    = 1'b0;
    assign o_fault = 1'b0;
`endif

    // Leg g uses bit g as its high command and bit g+2 as its low command.
    for (genvar g = 0; g < 2; g++) begin : g_leg
        assign want_high[g] = r_en & r_cmd[g] & ~r_cmd[g+2];
        assign want_low[g]  = r_en & r_cmd[g+2] & ~r_cmd[g];

        deadtime_gate_leg #(.DEADTIME(DEADTIME)) u_leg (
            .clk       (i_clock),
            .rst       (i_RESET),
            .want_high (want_high[g]),
            .want_low  (want_low[g]),
            .trip      (trip),
            .state     (leg_state[g]),
            .gate_high (gate_high[g]),
            .gate_low  (gate_low[g])
        );

        assign dead[g] = (leg_state[g] == 3'd3);
    end

    assign o_gate  = {gate_low, gate_high};
    assign o_debug = {leg_state[1], leg_state[0], dead[1], dead[0]};
endmodule

// File: tb/tb_deadtime_gate_driver.sv
// Bench for deadtime_gate_driver: vector table, hand-written dead-time sequences, and random
// stimulus checked against a minimum-off-interval reference model.

module tb_deadtime_gate_driver;
    localparam int DT = 50;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [3:0] cmd;
    logic [3:0] gate;
    logic       fault;
    logic [7:0] dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: registered command plus, per leg, the driven side (0 off, 1 high, 2 low)
    // and how many consecutive edges the leg has been off.
    logic [3:0] m_cmd;
    logic       m_en, m_fault;
    int         m_side [2];
    int         m_offrun [2];

    typedef struct {
        logic       r;
        logic       e;
        logic [3:0] c;
        logic [3:0] g;
        logic       f;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;

    deadtime_gate_driver #(.DEADTIME(DT)) dut (
        .i_clock  (clk),
        .i_RESET  (rst),
        .i_enable (en),
        .i_MOSFET (cmd),
        .o_gate   (gate),
        .o_fault  (fault),
        .o_debug  (dbg)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [3:0] c);
        int  req;
        logic h, l;
        if (r) begin
            m_cmd   = 4'b0000;
            m_en    = 1'b0;
            m_fault = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_side[i]   = 0;
                m_offrun[i] = DT;
            end
        end else begin
`ifdef DEADTIME_SHOOTTHROUGH_FAULT_EN
            if ((m_cmd[0] && m_cmd[2]) || (m_cmd[1] && m_cmd[3])) m_fault = 1'b1;
`endif
            for (int i = 0; i < 2; i++) begin
                h   = m_cmd[i];
                l   = m_cmd[i+2];
                req = !m_en ? 0 : (h && !l) ? 1 : (l && !h) ? 2 : 0;
                if (m_fault)                m_side[i] = 0;
                else if (m_side[i] != req) begin
                    if (m_side[i] != 0)     m_side[i] = 0;
                    else if (m_offrun[i] >= DT) m_side[i] = req;
                end
                if (m_side[i] == 0) m_offrun[i] = (m_offrun[i] < 10000) ? m_offrun[i] + 1 : m_offrun[i];
                else                m_offrun[i] = 0;
            end
            m_cmd = c;
            m_en  = e;
        end
    endtask

    function automatic logic [3:0] model_gate();
        return {m_side[1] == 2, m_side[0] == 2, m_side[1] == 1, m_side[0] == 1};
    endfunction

    task automatic step(input logic r, input logic e, input logic [3:0] c);
        rst = r;
        en  = e;
        cmd = c;
        @(posedge clk);
        model_edge(r, e, c);
        #1;
        chk("model_gate", 8'(gate), 8'(model_gate()));
        chk("model_fault", 8'(fault), 8'(m_fault));
    endtask

    task automatic stepx(input string name, input logic r, input logic e,
                         input logic [3:0] c, input logic [3:0] g);
        step(r, e, c);
        chk(name, 8'(gate), 8'(g));
    endtask

    // Reset, then bring 1001 (A high, B low) fully on.
    task automatic bring_on();
        repeat (2) step(1'b1, 1'b1, 4'b1001);
        stepx("on_latency1", 1'b0, 1'b1, 4'b1001, 4'b0000);
        stepx("on_latency2", 1'b0, 1'b1, 4'b1001, 4'b1001);
    endtask

    initial begin
        logic [3:0] rc;
        logic       re;
        int         n;

        tbl[0] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 4'b1001, 4'b0000, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 4'b1001, 4'b1001, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 4'b1001, 4'b1001, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 4'b0000, 4'b1001, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0};

        rst = 1'b1;
        en  = 1'b0;
        cmd = 4'b1111;

        for (int i = 0; i < 8; i++) begin
            step(tbl[i].r, tbl[i].e, tbl[i].c);
            chk($sformatf("tbl_gate[%0d]", i), 8'(gate), 8'(tbl[i].g));
            chk($sformatf("tbl_fault[%0d]", i), 8'(fault), 8'(tbl[i].f));
            if (i < 3) chk("reset_debug", dbg, 8'h00);
        end

        // Side swap: 1001 -> 0110, exactly DT all-off edges.
        bring_on();
        chk("debug_on", dbg, 8'h44);
        stepx("swap_edgeN", 1'b0, 1'b1, 4'b0110, 4'b1001);
        for (int k = 1; k <= DT; k++) begin
            stepx("swap_dead", 1'b0, 1'b1, 4'b0110, 4'b0000);
            if (k == 20) chk("debug_dead", dbg, 8'h6F);
        end
        stepx("swap_on", 1'b0, 1'b1, 4'b0110, 4'b0110);

        // Glitch on leg A for one cycle; leg B stays low-on throughout.
        bring_on();
        stepx("glitch_edgeN", 1'b0, 1'b1, 4'b1000, 4'b1001);
        for (int k = 1; k <= DT; k++) stepx("glitch_dead", 1'b0, 1'b1, 4'b1001, 4'b1000);
        stepx("glitch_reon", 1'b0, 1'b1, 4'b1001, 4'b1001);

        // Enable drop, re-enable after 10 cycles.
        bring_on();
        stepx("en_edgeN", 1'b0, 1'b0, 4'b1001, 4'b1001);
        for (int k = 1; k <= 9; k++)   stepx("en_off", 1'b0, 1'b0, 4'b1001, 4'b0000);
        for (int k = 10; k <= DT; k++) stepx("en_dead", 1'b0, 1'b1, 4'b1001, 4'b0000);
        stepx("en_reon", 1'b0, 1'b1, 4'b1001, 4'b1001);

        // Reset 20 cycles into dead interval.
        bring_on();
        stepx("rd_edgeN", 1'b0, 1'b1, 4'b0000, 4'b1001);
        for (int k = 1; k <= 20; k++) stepx("rd_dead", 1'b0, 1'b1, 4'b0000, 4'b0000);
        stepx("rd_reset", 1'b1, 1'b1, 4'b1001, 4'b0000);
        chk("rd_debug", dbg, 8'h00);
        stepx("rd_rel1", 1'b0, 1'b1, 4'b1001, 4'b0000);
        stepx("rd_rel2", 1'b0, 1'b1, 4'b1001, 4'b1001);

        // Shoot-through command on leg A.
        bring_on();
        stepx("st_edgeN", 1'b0, 1'b1, 4'b0101, 4'b1001);
        stepx("st_off", 1'b0, 1'b1, 4'b1001, 4'b0000);
`ifdef DEADTIME_SHOOTTHROUGH_FAULT_EN
        chk("st_fault", 8'(fault), 8'h01);
        for (int k = 0; k < DT + 10; k++) stepx("st_latched", 1'b0, 1'b1, 4'b1001, 4'b0000);
        chk("st_fault_held", 8'(fault), 8'h01);
        chk("st_debug", dbg, 8'h90);
        stepx("st_clear", 1'b1, 1'b1, 4'b1001, 4'b0000);
        chk("st_fault_clear", 8'(fault), 8'h00);
`else
        chk("st_nofault", 8'(fault), 8'h00);
        for (int k = 2; k <= DT; k++) stepx("st_dead", 1'b0, 1'b1, 4'b1001, 4'b0000);
        stepx("st_reon", 1'b0, 1'b1, 4'b1001, 4'b1001);
`endif

        // Random segments against the reference model.
        step(1'b1, 1'b0, 4'b0000);
        repeat (60) begin
            if ($urandom_range(0, 9) == 0) step(1'b1, 1'b1, 4'($urandom_range(0, 15)));
            rc = 4'($urandom_range(0, 15));
            re = ($urandom_range(0, 7) != 0);
            n  = $urandom_range(1, 70);
            repeat (n) step(1'b0, re, rc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
